sc_statemachineplayer: RTL and testbench

- Parametrised successor to the point/player control FSM in the Road Fighter datapath.
- Drives the player-car shift register through active-low clear/load strobes and the 2-bit shift select (11 hold, 01 left, 10 right).
- Adds hold-to-move auto-repeat with programmable delay and period, wall blocking from the side comparators, a pause enable, a blocked-move pulse and a wrapping move counter.

---
 rtl/sc_statemachineplayer_if.sv | 48 ++++
 rtl/sc_statemachineplayer.sv | 125 ++++++++++++
 tb/tb_sc_statemachineplayer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sc_statemachineplayer_if.sv
// Signal bundle between the player-car controller and its buttons, wall sensors and shift register.
// All signals are levels sampled on the rising clock edge. There is no valid/ready handshake on this bus.
interface sc_statemachineplayer_if #(
    parameter int MOVE_CNT_WIDTH = 8
);
    logic                      SC_STATEMACHINEPLAYER_startButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_leftButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_rightButton_InLow;
    logic                      SC_STATEMACHINEPLAYER_leftLimit_InLow;
    logic                      SC_STATEMACHINEPLAYER_rightLimit_InLow;
    logic                      SC_STATEMACHINEPLAYER_enable_InHigh;
    logic                      SC_STATEMACHINEPLAYER_clear_OutLow;
    logic                      SC_STATEMACHINEPLAYER_load_OutLow;
    logic [1:0]                SC_STATEMACHINEPLAYER_shiftselection_Out;
    logic                      SC_STATEMACHINEPLAYER_blocked_OutHigh;
    logic [MOVE_CNT_WIDTH-1:0] SC_STATEMACHINEPLAYER_moveCount_Out;
    logic [2:0]                SC_STATEMACHINEPLAYER_state_Dbg;

    modport slave (
        input  SC_STATEMACHINEPLAYER_startButton_InLow,
        input  SC_STATEMACHINEPLAYER_leftButton_InLow,
        input  SC_STATEMACHINEPLAYER_rightButton_InLow,
        input  SC_STATEMACHINEPLAYER_leftLimit_InLow,
        input  SC_STATEMACHINEPLAYER_rightLimit_InLow,
        input  SC_STATEMACHINEPLAYER_enable_InHigh,
        output SC_STATEMACHINEPLAYER_clear_OutLow,
        output SC_STATEMACHINEPLAYER_load_OutLow,
        output SC_STATEMACHINEPLAYER_shiftselection_Out,
        output SC_STATEMACHINEPLAYER_blocked_OutHigh,
        output SC_STATEMACHINEPLAYER_moveCount_Out,
        output SC_STATEMACHINEPLAYER_state_Dbg
    );

    modport master (
        output SC_STATEMACHINEPLAYER_startButton_InLow,
        output SC_STATEMACHINEPLAYER_leftButton_InLow,
        output SC_STATEMACHINEPLAYER_rightButton_InLow,
        output SC_STATEMACHINEPLAYER_leftLimit_InLow,
        output SC_STATEMACHINEPLAYER_rightLimit_InLow,
        output SC_STATEMACHINEPLAYER_enable_InHigh,
        input  SC_STATEMACHINEPLAYER_clear_OutLow,
        input  SC_STATEMACHINEPLAYER_load_OutLow,
        input  SC_STATEMACHINEPLAYER_shiftselection_Out,
        input  SC_STATEMACHINEPLAYER_blocked_OutHigh,
        input  SC_STATEMACHINEPLAYER_moveCount_Out,
        input  SC_STATEMACHINEPLAYER_state_Dbg
    );
endinterface

// File: rtl/sc_statemachineplayer.sv
// Player-car control FSM: init strobes, single and auto-repeat shifts, wall blocking and a move counter.
// All outputs decode registered state only.
module sc_statemachineplayer #(
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_PERIOD  = 4,
    parameter int CNT_WIDTH      = 26,
    parameter int MOVE_CNT_WIDTH = 8
) (
    input logic                  SC_STATEMACHINEPLAYER_CLOCK_50,
    input logic                  SC_STATEMACHINEPLAYER_RESET_InHigh,
    sc_statemachineplayer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_RESET, ST_START, ST_IDLE, ST_INIT_0,
        ST_INIT_1, ST_MOVE, ST_HOLD, ST_RELEASE
    } state_t;

    // The timer counts HOLD cycles down to 1; a load of N-1 after a move lands the next slot N cycles later.
    localparam logic [CNT_WIDTH-1:0] DELAY_LD    = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_LD   = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] PERIOD_FULL = CNT_WIDTH'(REPEAT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] TIMER_ONE   = CNT_WIDTH'(1);

    state_t                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      timer_q, timer_d;
    logic                      dir_q, dir_d;
    logic                      first_q, first_d;
    logic                      blocked_q, blocked_d;
    logic [MOVE_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic start_n, left_n, right_n, llim_n, rlim_n, en;
    logic dir_btn_n, dir_lim_n;

    assign start_n   = bus.SC_STATEMACHINEPLAYER_startButton_InLow;
    assign left_n    = bus.SC_STATEMACHINEPLAYER_leftButton_InLow;
    assign right_n   = bus.SC_STATEMACHINEPLAYER_rightButton_InLow;
    assign llim_n    = bus.SC_STATEMACHINEPLAYER_leftLimit_InLow;
    assign rlim_n    = bus.SC_STATEMACHINEPLAYER_rightLimit_InLow;
    assign en        = bus.SC_STATEMACHINEPLAYER_enable_InHigh;
    assign dir_btn_n = dir_q ? right_n : left_n;
    assign dir_lim_n = dir_q ? rlim_n : llim_n;

    always_ff @(posedge SC_STATEMACHINEPLAYER_CLOCK_50) begin
        if (SC_STATEMACHINEPLAYER_RESET_InHigh) begin
            state_q   <= ST_RESET;
            timer_q   <= '0;
            dir_q     <= 1'b0;
            first_q   <= 1'b0;
            blocked_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            dir_q     <= dir_d;
            first_q   <= first_d;
            blocked_q <= blocked_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dir_d     = dir_q;
        first_d   = first_q;
        blocked_d = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ST_RESET: state_d = ST_START;
            ST_START: state_d = ST_IDLE;
            ST_IDLE: begin
                if (!start_n) begin
                    state_d = ST_INIT_0;
                end else if (en && (!left_n || !right_n)) begin
                    // Left wins when both are pressed.
                    dir_d = left_n;
                    if ((left_n ? rlim_n : llim_n)) begin
                        state_d = ST_MOVE;
                        first_d = 1'b1;
                    end else begin
                        state_d   = ST_RELEASE;
                        blocked_d = 1'b1;
                    end
                end
            end
            ST_INIT_0: begin
                cnt_d   = '0;
                state_d = ST_INIT_1;
            end
            ST_INIT_1: state_d = ST_RELEASE;
            ST_MOVE: begin
                cnt_d   = cnt_q + 1'b1;
                timer_d = first_q ? DELAY_LD : PERIOD_LD;
                first_d = 1'b0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (dir_btn_n || !en) begin
                    state_d = ST_RELEASE;
                end else if (timer_q == TIMER_ONE) begin
                    if (dir_lim_n) begin
                        state_d = ST_MOVE;
                    end else begin
                        // The blocked pulse takes the move's slot, so the next slot is a full period on.
                        blocked_d = 1'b1;
                        timer_d   = PERIOD_FULL;
                    end
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_RELEASE: begin
                if (start_n && left_n && right_n) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.SC_STATEMACHINEPLAYER_clear_OutLow       = (state_q != ST_INIT_0);
    assign bus.SC_STATEMACHINEPLAYER_load_OutLow        = (state_q != ST_INIT_1);
    assign bus.SC_STATEMACHINEPLAYER_shiftselection_Out = (state_q == ST_MOVE) ? (dir_q ? 2'b10 : 2'b01) : 2'b11;
    assign bus.SC_STATEMACHINEPLAYER_blocked_OutHigh    = blocked_q;
    assign bus.SC_STATEMACHINEPLAYER_moveCount_Out      = cnt_q;
    assign bus.SC_STATEMACHINEPLAYER_state_Dbg          = state_q;
endmodule

// File: tb/tb_sc_statemachineplayer.sv
// Bench for sc_statemachineplayer: directed scenarios plus random button traffic checked every cycle
// against a schedule-based model (press age, repeat slots at DELAY + k*PERIOD).
module tb_sc_statemachineplayer;
    localparam int D  = 8;
    localparam int P  = 4;
    localparam int CW = 8;

    localparam int PH_BOOT = 0, PH_IDLE = 1, PH_CLR = 2, PH_LD = 3, PH_PRESS = 4, PH_REL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sc_statemachineplayer_if #(.MOVE_CNT_WIDTH(CW)) bus ();

    sc_statemachineplayer #(
        .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .CNT_WIDTH(26), .MOVE_CNT_WIDTH(CW)
    ) dut (
        .SC_STATEMACHINEPLAYER_CLOCK_50(clk),
        .SC_STATEMACHINEPLAYER_RESET_InHigh(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model state
    int          ph = PH_BOOT;
    int          boot_left = 2;
    int          age = 0;
    bit          m_dir = 1'b0;
    bit          m_pulse = 1'b0;
    bit          m_blk = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_slot(input int a);
        return (a == D) || (a > D && ((a - D) % P) == 0);
    endfunction

    // Advance the model over one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit was_pulse, btn_n, lim_n, s_n, l_n, r_n, ll_n, rl_n, en;
        s_n  = bus.SC_STATEMACHINEPLAYER_startButton_InLow;
        l_n  = bus.SC_STATEMACHINEPLAYER_leftButton_InLow;
        r_n  = bus.SC_STATEMACHINEPLAYER_rightButton_InLow;
        ll_n = bus.SC_STATEMACHINEPLAYER_leftLimit_InLow;
        rl_n = bus.SC_STATEMACHINEPLAYER_rightLimit_InLow;
        en   = bus.SC_STATEMACHINEPLAYER_enable_InHigh;
        was_pulse = m_pulse;
        m_pulse = 1'b0;
        m_blk   = 1'b0;
        if (rst) begin
            ph = PH_BOOT;
            boot_left = 2;
            m_cnt = '0;
            return;
        end
        if (was_pulse) m_cnt = m_cnt + 1'b1;
        btn_n = m_dir ? r_n : l_n;
        lim_n = m_dir ? rl_n : ll_n;
        case (ph)
            PH_BOOT: begin
                boot_left--;
                if (boot_left == 0) ph = PH_IDLE;
            end
            PH_IDLE: begin
                if (!s_n) begin
                    ph = PH_CLR;
                end else if (en && (!l_n || !r_n)) begin
                    m_dir = l_n;
                    lim_n = m_dir ? rl_n : ll_n;
                    if (lim_n) begin
                        ph = PH_PRESS;
                        age = 0;
                        m_pulse = 1'b1;
                    end else begin
                        ph = PH_REL;
                        m_blk = 1'b1;
                    end
                end
            end
            PH_CLR: begin
                m_cnt = '0;
                ph = PH_LD;
            end
            PH_LD: ph = PH_REL;
            PH_PRESS: begin
                if (was_pulse) begin
                    age++;
                end else if (btn_n || !en) begin
                    ph = PH_REL;
                end else begin
                    age++;
                    if (is_slot(age)) begin
                        if (lim_n) m_pulse = 1'b1;
                        else       m_blk = 1'b1;
                    end
                end
            end
            default: begin
                if (s_n && l_n && r_n) ph = PH_IDLE;
            end
        endcase
    endtask

    task automatic step(input int n);
        logic [1:0] exp_shift;
        for (int i = 0; i < n; i++) begin
            model_edge();
            @(posedge clk);
            #1;
            exp_shift = m_pulse ? (m_dir ? 2'b10 : 2'b01) : 2'b11;
            check_eq("clear", 32'(bus.SC_STATEMACHINEPLAYER_clear_OutLow), 32'(ph != PH_CLR));
            check_eq("load", 32'(bus.SC_STATEMACHINEPLAYER_load_OutLow), 32'(ph != PH_LD));
            check_eq("shift", 32'(bus.SC_STATEMACHINEPLAYER_shiftselection_Out), 32'(exp_shift));
            check_eq("blocked", 32'(bus.SC_STATEMACHINEPLAYER_blocked_OutHigh), 32'(m_blk));
            check_eq("move_count", 32'(bus.SC_STATEMACHINEPLAYER_moveCount_Out), 32'(m_cnt));
        end
    endtask

    task automatic set_buttons(input bit s_n, input bit l_n, input bit r_n);
        bus.SC_STATEMACHINEPLAYER_startButton_InLow = s_n;
        bus.SC_STATEMACHINEPLAYER_leftButton_InLow  = l_n;
        bus.SC_STATEMACHINEPLAYER_rightButton_InLow = r_n;
    endtask

    task automatic set_env(input bit ll_n, input bit rl_n, input bit en);
        bus.SC_STATEMACHINEPLAYER_leftLimit_InLow  = ll_n;
        bus.SC_STATEMACHINEPLAYER_rightLimit_InLow = rl_n;
        bus.SC_STATEMACHINEPLAYER_enable_InHigh    = en;
    endtask

    initial begin
        set_buttons(1, 1, 1);
        set_env(1, 1, 1);

        // Reset held 3 cycles, then boot into idle
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(4);

        // Start tap: clear then load strobes
        set_buttons(0, 1, 1); step(1);
        set_buttons(1, 1, 1); step(5);

        // Left tap: one pulse, no repeat
        set_buttons(1, 0, 1); step(2);
        set_buttons(1, 1, 1); step(12);

        // Right held: pulses at t, t+8, t+12, t+16, t+20
        set_buttons(1, 1, 0); step(22);
        set_buttons(1, 1, 1); step(4);

        // Left held, wall appears at t+5
        set_buttons(1, 0, 1); step(6);
        set_env(0, 1, 1); step(10);
        set_buttons(1, 1, 1); step(3);
        // Left pressed against the wall from idle
        set_buttons(1, 0, 1); step(3);
        set_buttons(1, 1, 1); step(3);
        set_env(1, 1, 1);

        // Paused: moves ignored, start honoured
        set_env(1, 1, 0);
        set_buttons(1, 0, 1); step(3);
        set_buttons(1, 1, 0); step(3);
        set_buttons(0, 1, 1); step(1);
        set_buttons(1, 1, 1); step(5);
        set_env(1, 1, 1);

        // Both directions together
        set_buttons(1, 0, 0); step(3);
        set_buttons(1, 1, 1); step(4);

        // Reset in the middle of a hold
        set_buttons(1, 1, 0); step(5);
        rst = 1'b1; step(1);
        rst = 1'b0; set_buttons(1, 1, 1); step(4);

        // 256 taps wrap the counter
        for (int k = 0; k < 256; k++) begin
            set_buttons(1, k[0], !k[0]); step(1);
            set_buttons(1, 1, 1); step(3);
        end
        step(2);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0)
                bus.SC_STATEMACHINEPLAYER_startButton_InLow = ~bus.SC_STATEMACHINEPLAYER_startButton_InLow;
            if ($urandom_range(0, 11) == 0)
                bus.SC_STATEMACHINEPLAYER_leftButton_InLow = ~bus.SC_STATEMACHINEPLAYER_leftButton_InLow;
            if ($urandom_range(0, 11) == 0)
                bus.SC_STATEMACHINEPLAYER_rightButton_InLow = ~bus.SC_STATEMACHINEPLAYER_rightButton_InLow;
            if ($urandom_range(0, 15) == 0)
                bus.SC_STATEMACHINEPLAYER_leftLimit_InLow = ~bus.SC_STATEMACHINEPLAYER_leftLimit_InLow;
            if ($urandom_range(0, 15) == 0)
                bus.SC_STATEMACHINEPLAYER_rightLimit_InLow = ~bus.SC_STATEMACHINEPLAYER_rightLimit_InLow;
            if ($urandom_range(0, 29) == 0)
                bus.SC_STATEMACHINEPLAYER_enable_InHigh = ~bus.SC_STATEMACHINEPLAYER_enable_InHigh;
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
